// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter in front of a small internal memory with boot contents.
// Define ARB_FIXED_PRIORITY_EN to make requester A always win ties (B may starve).
module mem_access_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic                  cur_b;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  grant_a;

  function automatic logic [DATA_WIDTH-1:0] boot_word(input int idx);
    case (idx)
      0:       boot_word = DATA_WIDTH'(4'b0100);
      1:       boot_word = DATA_WIDTH'(4'b1100);
      2:       boot_word = DATA_WIDTH'(4'b0110);
      3:       boot_word = DATA_WIDTH'(4'b0111);
      default: boot_word = '0;
    endcase
  endfunction

`ifdef ARB_FIXED_PRIORITY_EN
  assign grant_a = req_a;
`else
  logic last_grant_b;
  // On a tie A wins only if B was the previous winner.
  assign grant_a = req_a & (~req_b | last_grant_b);
`endif

  // NOTE: all state, including the memory array, updates with non-blocking
  // assignments; the memory is in the reset branch because reset must reload
  // the boot table, so this array maps to flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      cur_b     <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_b <= 1'b1;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word(i);
    end else begin
      case (state)
        IDLE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          if (req_a | req_b) begin
            cur_b     <= ~grant_a;
            cur_we    <= grant_a ? we_a    : we_b;
            cur_addr  <= grant_a ? addr_a  : addr_b;
            cur_wdata <= grant_a ? wdata_a : wdata_b;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant_b <= ~grant_a;
`endif
            busy  <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cur_we) begin
            mem[cur_addr] <= cur_wdata;
            rdata         <= cur_wdata;
          end else begin
            rdata <= mem[cur_addr];
          end
          ack_a <= ~cur_b;
          ack_b <= cur_b;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_mem_access_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [1:0] addr_a = '0, addr_b = '0;
  logic [3:0] wdata_a = '0, wdata_b = '0;
  logic       ack_a, ack_b, busy;
  logic [3:0] rdata;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] last_rdata = '0;

  mem_access_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_b;
    bit         we;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset ack_a", 32'(ack_a), 0);
    check("reset ack_b", 32'(ack_b), 0);
    check("reset busy", 32'(busy), 0);
    check("reset rdata", 32'(rdata), 0);
    @(negedge clock);
    reset_n = 1'b1;
    last_rdata = '0;
  endtask

  // One single-requester access: request sampled at the next edge, ack two edges later.
  task automatic do_access(input bit is_b, input bit we, input logic [1:0] addr,
                           input logic [3:0] wdata, input logic [3:0] exp, input string tag);
    @(negedge clock);
    check({tag, " idle acks"}, 32'({ack_a, ack_b}), 0);
    check({tag, " rdata hold"}, 32'(rdata), 32'(last_rdata));
    if (is_b) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    end
    @(negedge clock);
    check({tag, " busy"}, 32'(busy), 1);
    check({tag, " early ack"}, 32'({ack_a, ack_b}), 0);
    @(negedge clock);
    check({tag, " ack"}, 32'({ack_a, ack_b}), is_b ? 32'b01 : 32'b10);
    check({tag, " rdata"}, 32'(rdata), 32'(exp));
    check({tag, " busy off"}, 32'(busy), 0);
    last_rdata = exp;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    logic [3:0] model_mem [4];
    bit         model_last_b;
    int         cnt;

    vecs[0] = '{is_b: 0, we: 0, addr: 2'd0, wdata: 4'h0, exp_rdata: 4'b0100};
    vecs[1] = '{is_b: 0, we: 0, addr: 2'd1, wdata: 4'h0, exp_rdata: 4'b1100};
    vecs[2] = '{is_b: 0, we: 0, addr: 2'd2, wdata: 4'h0, exp_rdata: 4'b0110};
    vecs[3] = '{is_b: 0, we: 0, addr: 2'd3, wdata: 4'h0, exp_rdata: 4'b0111};
    vecs[4] = '{is_b: 1, we: 1, addr: 2'd2, wdata: 4'b1010, exp_rdata: 4'b1010};
    vecs[5] = '{is_b: 0, we: 0, addr: 2'd2, wdata: 4'h0, exp_rdata: 4'b1010};

    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;

    // Boot-content reads, then B write followed by A read-after-write.
    do_reset();
    for (int i = 0; i < 6; i++)
      do_access(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Both requesters held high for four accesses.
    do_reset();
    @(negedge clock);
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k % 2 == 0) begin
        check($sformatf("tie%0d busy", k), 32'(busy), 1);
        check($sformatf("tie%0d no ack", k), 32'({ack_a, ack_b}), 0);
      end else begin
        bit exp_b;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_b = 1'b0;
`else
        exp_b = ((k / 2) % 2) == 1;
`endif
        check($sformatf("tie%0d grant", k), 32'({ack_a, ack_b}), exp_b ? 32'b01 : 32'b10);
        check($sformatf("tie%0d rdata", k), 32'(rdata), exp_b ? 32'b1100 : 32'b0100);
        check($sformatf("tie%0d busy off", k), 32'(busy), 0);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset during a write's ACCESS cycle: no ack, write discarded.
    do_reset();
    @(negedge clock);
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd1; wdata_a = 4'b0001;
    @(negedge clock);
    check("abort busy", 32'(busy), 1);
    reset_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0;
    #1;
    check("abort ack_a", 32'(ack_a), 0);
    check("abort busy off", 32'(busy), 0);
    @(negedge clock);
    check("abort ack_a later", 32'(ack_a), 0);
    reset_n = 1'b1;
    last_rdata = '0;
    do_access(1'b0, 1'b0, 2'd1, 4'h0, 4'b1100, "abort readback");

    // A one-cycle req_b pulse yields exactly one access.
    do_reset();
    @(negedge clock);
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd3;
    @(negedge clock);
    req_b = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (ack_b) begin
        cnt++;
        check("pulse rdata", 32'(rdata), 32'b0111);
      end
    end
    check("pulse ack_b count", 32'(cnt), 1);

    // Randomized traffic against a transaction-level model.
    do_reset();
    model_mem[0] = 4'b0100; model_mem[1] = 4'b1100;
    model_mem[2] = 4'b0110; model_mem[3] = 4'b0111;
    model_last_b = 1'b1;
    for (int t = 0; t < 40; t++) begin
      bit         ra, rb, wa, wb, win_b, w_we;
      logic [1:0] aa, ab, w_addr;
      logic [3:0] da, db, w_data, exp;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      aa = 2'($urandom_range(0, 3)); ab = 2'($urandom_range(0, 3));
      da = 4'($urandom_range(0, 15)); db = 4'($urandom_range(0, 15));
      if (ra && rb) begin
`ifdef ARB_FIXED_PRIORITY_EN
        win_b = 1'b0;
`else
        win_b = !model_last_b;
`endif
      end else begin
        win_b = rb;
      end
      w_we   = win_b ? wb : wa;
      w_addr = win_b ? ab : aa;
      w_data = win_b ? db : da;
      exp    = w_we ? w_data : model_mem[w_addr];

      @(negedge clock);
      req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
      @(negedge clock);
      check($sformatf("rnd%0d busy", t), 32'(busy), 1);
      @(negedge clock);
      check($sformatf("rnd%0d grant", t), 32'({ack_a, ack_b}), win_b ? 32'b01 : 32'b10);
      check($sformatf("rnd%0d rdata", t), 32'(rdata), 32'(exp));
      req_a = 1'b0;
      req_b = 1'b0;
      if (w_we) model_mem[w_addr] = w_data;
      model_last_b = win_b;
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
